// File: rtl/init_ram_pkg.sv
// Shared definitions for the self-initialising lookup table: controller states
// and the fill-pattern arithmetic used by the loader.
package init_ram_pkg;

  typedef enum logic [0:0] {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_e;

  // Wide enough for ADDR_W+32 bit products with any address width the table can use.
  localparam int unsigned CALC_W = 64;

  function automatic logic [CALC_W-1:0] init_value(
    input logic [CALC_W-1:0] idx,
    input logic [CALC_W-1:0] step,
    input int unsigned       width
  );
    logic [CALC_W-1:0] prod;
    logic [CALC_W-1:0] mask;
    prod = idx * step;
    if (width >= CALC_W) begin
      mask = '1;
    end else begin
      mask = (CALC_W'(1) << width) - CALC_W'(1);
    end
    return prod & mask;
  endfunction

endpackage

// File: rtl/ram_core.sv
// Plain 1R1W storage array: read-first, registered read port, contents never reset.
// clr zeroes only the read register (reset or an out-of-range read).
module ram_core
  import init_ram_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int DEPTH  = 8,
  parameter int IDX_W  = 3
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [IDX_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Non-blocking read of mem returns the pre-write value on an address collision.
  always_ff @(posedge clk) begin
    if (clr) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/init_ram.sv
// Self-loading lookup table: fills entry i with i*STEP after reset or reinit,
// then serves registered reads and run-time writes with range checking.
//
//   state    | meaning
//   ---------+---------------------------------------------------------------
//   INIT     | loader writes one entry per cycle, user ports ignored, busy=1
//   READY    | user reads/writes served, reinit restarts the fill from 0
module init_ram
  import init_ram_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 8,
  parameter int STEP   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              reinit,
  output logic              init_busy,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_err,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);
  localparam logic [0:0]        S_INIT    = ST_INIT;
  localparam logic [0:0]        S_READY   = ST_READY;

  logic [0:0]        state_q;
  logic [IDX_W-1:0]  fill_ptr_q;
  logic              rd_valid_q;
  logic              rd_err_q;

  logic              ready;
  logic              rd_in_range;
  logic              wr_in_range;
  logic              rd_accept;
  logic              wr_accept;
  logic [DATA_W-1:0] fill_value;

  logic              core_we;
  logic [IDX_W-1:0]  core_waddr;
  logic [DATA_W-1:0] core_wdata;
  logic              core_re;
  logic              core_clr;

  assign ready       = (state_q == S_READY);
  assign rd_in_range = ({1'b0, rd_addr} < DEPTH_EXT);
  assign wr_in_range = ({1'b0, wr_addr} < DEPTH_EXT);

  // reinit wins over user traffic in the cycle it is accepted.
  assign rd_accept = ready && rd_en && !reinit;
  assign wr_accept = ready && wr_en && !reinit && wr_in_range;

  assign fill_value = DATA_W'(init_value(CALC_W'(fill_ptr_q), CALC_W'(STEP), DATA_W));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_INIT;
      fill_ptr_q <= '0;
    end else if (state_q == S_INIT) begin
      if (fill_ptr_q == LAST_IDX) begin
        state_q    <= S_READY;
        fill_ptr_q <= '0;
      end else begin
        fill_ptr_q <= fill_ptr_q + IDX_W'(1);
      end
    end else begin
      if (reinit) begin
        state_q <= S_INIT;
      end
      fill_ptr_q <= '0;
    end
  end

  always_comb begin
    core_we    = 1'b0;
    core_waddr = fill_ptr_q;
    core_wdata = fill_value;
    if (!rst) begin
      if (state_q == S_INIT) begin
        core_we = 1'b1;
      end else if (wr_accept) begin
        core_we    = 1'b1;
        core_waddr = wr_addr[IDX_W-1:0];
        core_wdata = wr_data;
      end
    end
  end

  // Out-of-range reads return zero, so they clear the read register instead of loading it.
  assign core_re  = rd_accept && rd_in_range;
  assign core_clr = rst || (rd_accept && !rd_in_range);

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid_q <= 1'b0;
      rd_err_q   <= 1'b0;
    end else begin
      rd_valid_q <= rd_accept;
      rd_err_q   <= rd_accept && !rd_in_range;
    end
  end

  ram_core #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_ram_core (
    .clk   (clk),
    .clr   (core_clr),
    .we    (core_we),
    .waddr (core_waddr),
    .wdata (core_wdata),
    .re    (core_re),
    .raddr (rd_addr[IDX_W-1:0]),
    .rdata (rd_data)
  );

  assign init_busy = (state_q == S_INIT);
  assign rd_valid  = rd_valid_q;
  assign rd_err    = rd_err_q;

endmodule

// File: tb/tb_init_ram.sv
// Bench for init_ram: default instance and a DATA_W=3/DEPTH=5/STEP=3 instance driven
// in lockstep, each checked against its own table model through a response scoreboard.
module tb_init_ram;

  typedef struct packed {
    logic       v;
    logic       e;
    logic [3:0] d;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       reinit = 1'b0;
  logic       rd_en = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] rd_addr = '0;
  logic [7:0] wr_addr = '0;
  logic [3:0] wr_data = '0;

  logic       busy_a, valid_a, err_a;
  logic [3:0] data_a;
  logic       busy_b, valid_b, err_b;
  logic [2:0] data_b;

  always #5 clk = ~clk;

  init_ram u_dut_a (
    .clk       (clk),
    .rst       (rst),
    .reinit    (reinit),
    .init_busy (busy_a),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .rd_valid  (valid_a),
    .rd_data   (data_a),
    .rd_err    (err_a),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data)
  );

  init_ram #(.DATA_W(3), .DEPTH(5), .ADDR_W(8), .STEP(3)) u_dut_b (
    .clk       (clk),
    .rst       (rst),
    .reinit    (reinit),
    .init_busy (busy_b),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .rd_valid  (valid_b),
    .rd_data   (data_b),
    .rd_err    (err_b),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data[2:0])
  );

  int   dep [2] = '{8, 5};
  int   stp [2] = '{2, 3};
  int   dw  [2] = '{4, 3};
  int   mem [2][8];
  int   busy_left [2] = '{0, 0};
  int   hold [2] = '{0, 0};
  exp_t q0 [$];
  exp_t q1 [$];
  int   total = 0;
  int   bad = 0;
  bit   started = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic fill(input int k);
    for (int i = 0; i < dep[k]; i++) mem[k][i] = (i * stp[k]) % (1 << dw[k]);
  endtask

  // One clock edge of the table's observable behaviour, from the current inputs.
  task automatic model_edge(input int k);
    exp_t r;
    int   mask;
    mask = (1 << dw[k]) - 1;
    r.v = 1'b0;
    r.e = 1'b0;
    r.d = 4'(hold[k]);
    if (rst) begin
      fill(k);
      busy_left[k] = dep[k];
      hold[k] = 0;
      r.d = 4'd0;
    end else if (busy_left[k] > 0) begin
      busy_left[k]--;
    end else if (reinit) begin
      fill(k);
      busy_left[k] = dep[k];
    end else begin
      if (rd_en) begin
        r.v = 1'b1;
        if (int'(rd_addr) < dep[k]) begin
          hold[k] = mem[k][rd_addr];
          r.e = 1'b0;
        end else begin
          hold[k] = 0;
          r.e = 1'b1;
        end
        r.d = 4'(hold[k]);
      end
      if (wr_en && int'(wr_addr) < dep[k]) mem[k][wr_addr] = int'(wr_data) & mask;
    end
    if (k == 0) q0.push_back(r);
    else q1.push_back(r);
  endtask

  task automatic cyc(input logic r, input logic ri, input logic re, input int ra,
                     input logic we, input int wa, input int wd);
    @(negedge clk);
    if (started) begin
      chk("busy_a", 32'(busy_a), 32'(busy_left[0] > 0));
      chk("busy_b", 32'(busy_b), 32'(busy_left[1] > 0));
    end
    rst = r;
    reinit = ri;
    rd_en = re;
    rd_addr = 8'(ra);
    wr_en = we;
    wr_addr = 8'(wa);
    wr_data = 4'(wd);
    model_edge(0);
    model_edge(1);
    if (r) started = 1'b1;
  endtask

  task automatic dump();
    for (int i = 0; i < 8; i++) cyc(0, 0, 1, i, 0, 0, 0);
  endtask

  always @(posedge clk) begin
    exp_t ea;
    exp_t eb;
    #1;
    if (q0.size() > 0) begin
      ea = q0.pop_front();
      chk("rd_valid_a", 32'(valid_a), 32'(ea.v));
      chk("rd_err_a", 32'(err_a), 32'(ea.e));
      chk("rd_data_a", 32'(data_a), 32'(ea.d));
    end
    if (q1.size() > 0) begin
      eb = q1.pop_front();
      chk("rd_valid_b", 32'(valid_b), 32'(eb.v));
      chk("rd_err_b", 32'(err_b), 32'(eb.e));
      chk("rd_data_b", 32'(data_b), 32'(eb.d));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    int ra, wa;
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    // Traffic while filling: ignored by the default table, partly served by the small one.
    for (int i = 0; i < 8; i++) cyc(0, 0, 1, i, 1, i, 15);
    dump();
    cyc(0, 0, 1, 3, 1, 3, 9);
    cyc(0, 0, 1, 3, 0, 0, 0);
    cyc(0, 0, 1, 8, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 200, 5);
    cyc(0, 0, 1, 255, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    dump();
    cyc(0, 0, 0, 0, 1, 0, 7);
    cyc(0, 0, 0, 0, 1, 6, 1);
    cyc(0, 0, 1, 0, 0, 0, 0);
    cyc(0, 1, 1, 0, 1, 2, 3);
    for (int i = 0; i < 9; i++) cyc(0, 0, 1, $urandom_range(0, 7), 0, 0, 0);
    dump();
    cyc(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) cyc(0, 0, 1, i, 0, 0, 0);
    cyc(1, 0, 1, 2, 1, 2, 11);
    for (int i = 0; i < 10; i++) cyc(0, 0, 1, $urandom_range(0, 7), 0, 0, 0);
    dump();
    cyc(0, 0, 1, 1, 1, 1, 13);
    cyc(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 100; i++) begin
      ra = ($urandom_range(0, 9) == 0) ? 255 : $urandom_range(0, 9);
      wa = ($urandom_range(0, 9) == 0) ? 200 : $urandom_range(0, 9);
      cyc($urandom_range(0, 59) == 0, $urandom_range(0, 19) == 0,
          1'($urandom_range(0, 1)), ra, 1'($urandom_range(0, 1)), wa, $urandom_range(0, 15));
    end
    for (int i = 0; i < 10; i++) cyc(0, 0, 0, 0, 0, 0, 0);
    dump();
    cyc(0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #3;
    chk("queue_a_drained", 32'(q0.size()), 32'd0);
    chk("queue_b_drained", 32'(q1.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
